// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadowed data and a per-slot anode guard.
// Optional leading-zero blanking is compiled in with `define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 16,
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        digit_idx
);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    tick;
  logic                    show;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h0C;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (tick) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more-significant nibble are zero, unless its dp is lit.
  always_comb begin
    lz_blank = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++)
      lz_blank[i] = ((shadow_val_q >> (4 * i)) == '0) && !shadow_dp_q[i];
  end
`else
  always_comb lz_blank = '0;
`endif

  // Output register samples the pre-edge scan state, so every output lags cnt/idx by one cycle.
  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    show  = (cnt_q >= CNT_W'(GUARD)) && digit_en[idx_q] && !lz_blank[idx_q];
    if (show) begin
      seg_d        = decode(shadow_val_q[{idx_q, 2'b00} +: 4]);
      dp_d         = ~shadow_dp_q[idx_q];
      an_d[idx_q]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg_n     = seg_q;
  assign dp_n      = dp_q;
  assign an_n      = an_q;
  assign digit_idx = idx_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display.
- Latches a packed hex word plus decimal points into a shadow register on `load`.
- Scans one digit per refresh slot and decodes each nibble to active-low segments.
- Inserts an anti-ghosting guard at the start of each slot.
- Sits between datapath or debug registers and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, range 1..8.
- REFRESH_DIV, 100000: clock cycles per digit slot, at least 2.
- GUARD, 16: cycles at the start of each slot during which all anodes are off; must be less than REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value and dp_in into the shadow register.
- value  in  4*NUM_DIGITS  packed nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable, sampled live (not shadowed); 0 = digit kept dark.
- seg_n  out  7  registered, active-low {a,b,c,d,e,f,g}; seg_n[6] = a.
- dp_n  out  1  registered, active-low decimal point.
- an_n  out  NUM_DIGITS  registered, active-low anode selects; at most one low at any time.
- digit_idx  out  clog2(NUM_DIGITS), minimum 1  current scan index.

Behaviour:
- Reset (async assert, released synchronously by the user):
  - cnt = 0, digit_idx = 0, shadow value = 0, shadow dp = 0.
  - seg_n = 7'h7F, dp_n = 1, an_n = all ones.
- Refresh counter cnt:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
  - On tick, digit_idx increments; from NUM_DIGITS-1 it wraps to 0.
- Shadow register:
  - Updates on the clock edge where load=1.
  - Between loads, the display shows the shadow contents only; value and dp_in changes are otherwise ignored.
- Output register (all outputs change together on one edge):
  - Samples cnt, digit_idx, shadow and digit_en of the current cycle, giving 1-cycle latency.
  - If cnt < GUARD or digit_en[digit_idx]=0: an_n = all ones, seg_n = 7'h7F, dp_n = 1.
  - Otherwise: an_n has only bit digit_idx low, seg_n = decode(shadow nibble digit_idx), dp_n = ~shadow_dp[digit_idx].
- Decode table, as 7-bit hex of {a..g}:
  - 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
  - 8:00, 9:0C, A:08, B:60, C:31, D:42, E:30, F:38
  - Any X/illegal value: 7F.
- Timing after load:
  - A loaded value appears on seg_n no later than the second edge after the load edge, provided the slot is active.
  - load coinciding with tick: the shadow update and index advance both occur on that edge; the new digit shows the new data.
- Repeated load with the same data: no visible glitch; outputs are unchanged.
- Reset mid-scan: all outputs immediately return to reset values (asynchronous); scanning restarts at digit 0, cnt = 0.
- NUM_DIGITS = 1: digit_idx stays 0 and the digit is re-guarded every REFRESH_DIV cycles.
- Scan period is NUM_DIGITS*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-GUARD cycles per period.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined:
  - Digit i is treated as disabled (dark; an_n high, seg_n 7F, dp_n 1) if every shadow nibble at index i and above is 0 and i > 0.
  - Exception: a digit with its shadow dp bit set is never blanked.
  - Digit 0 is always shown, subject to digit_en.
- When undefined: all enabled digits display, including leading zeros. Logic and ports are otherwise identical.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, GUARD=1):
- Release reset, no load -> first edge: an_n=4'b1111; second edge: an_n=4'b1110, seg_n=7'h01; after 8 more cycles: an_n=4'b1101, digit_idx=1.
- load value=16'hA5C3, dp_in=4'b0100, digit_en=4'hF -> slots show seg_n 06 (digit 0), 31 (digit 1), 24 with dp_n=0 (digit 2), 08 (digit 3), then wrap to digit 0.
- digit_en=4'b1011 with value 16'h1234 loaded -> during digit 2's slot an_n=4'b1111, seg_n=7F; other digits decode normally.
- Guard check -> on the first output edge after every tick, an_n=all ones; never more than one an_n bit low in any cycle.
- Assert reset in the middle of digit 2's slot -> same-cycle outputs 7F / 1 / 4'b1111; after release the sequence restarts from digit 0.
- With SEG7_LEADING_ZERO_BLANK_EN, load value=16'h0050, dp_in=0 -> digits 3 and 2 dark, digit 1 shows 24, digit 0 shows 01; reload dp_in=4'b1000 -> digit 3 shows 01 with dp_n=0.
